// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES constants: forward/inverse S-box tables, iterator state enum, block byte count.
package inv_sub_bytes_iter_pkg;

  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box lookup, one byte per instance.
import inv_sub_bytes_iter_pkg::*;

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = INV_SBOX[a];
endmodule

// File: rtl/aes_sbox.sv
// Combinational forward S-box lookup, used to cross-check inverse lane outputs.
import inv_sub_bytes_iter_pkg::*;

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES inverse S-boxes swept over the 16-byte state in 16/LANES cycles.
// INV_SUB_BYTES_CHECK_EN adds forward S-boxes on each lane and a sticky err output.
import inv_sub_bytes_iter_pkg::*;

module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ip,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] op,
  output logic         out_valid,
  input  logic         out_ready
`ifdef INV_SUB_BYTES_CHECK_EN
  ,output logic        err
`endif
);
  localparam int N  = AES_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = 8 * LANES;

  state_t                 st, st_nxt;
  logic [127:0]           data;
  logic [CW-1:0]          cnt;
  logic                   mode;
  logic                   last, accept, wr;
  logic [7:0]             base;
  logic [LANES-1:0][7:0]  lin, lout;

  assign last   = (cnt == CW'(N - 1));
  assign accept = (st == IDLE) && in_valid;
  assign wr     = (st == BUSY) && mode;
  // Lane window slides up by LANES bytes per BUSY cycle, lowest bytes first.
  assign base   = 8'(cnt) * 8'(LW);
  assign lin    = data[base +: LW];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_inv_sbox u_isb (.a(lin[g]), .y(lout[g]));
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid) st_nxt = enable ? BUSY : DONE;
      BUSY:    if (last) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      cnt  <= '0;
      data <= '0;
      mode <= 1'b0;
    end else begin
      st <= st_nxt;
      if (accept) begin
        data <= ip;
        cnt  <= '0;
        mode <= enable;
      end else if (st == BUSY) begin
        if (wr) data[base +: LW] <= lout;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign op        = data;

`ifdef INV_SUB_BYTES_CHECK_EN
  logic [LANES-1:0][7:0] fwd;
  logic [LANES-1:0]      bad;

  // Round-trip each freshly produced byte back through the forward table.
  for (genvar g = 0; g < LANES; g++) begin : g_chk
    aes_sbox u_sb (.a(lout[g]), .y(fwd[g]));
    assign bad[g] = (fwd[g] != lin[g]);
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (wr && |bad) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter (LANES=4), plus LANES=1/16 instances checked against a GF(2^8) model.
module tb_inv_sub_bytes_iter;
  logic         clk = 1'b0;
  logic         rst, enable, in_valid, out_ready;
  logic [127:0] ip, op;
  logic         in_ready, out_valid;
  logic [127:0] ipx, op1, op16;
  logic         ivx, in_ready1, ov1, in_ready16, ov16;
  logic         err, err1, err16;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .ip(ip), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .out_valid(out_valid), .out_ready(out_ready)
`ifdef INV_SUB_BYTES_CHECK_EN
    , .err(err)
`endif
  );

  inv_sub_bytes_iter #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst), .ip(ipx), .enable(1'b1), .in_valid(ivx), .in_ready(in_ready1),
    .op(op1), .out_valid(ov1), .out_ready(1'b1)
`ifdef INV_SUB_BYTES_CHECK_EN
    , .err(err1)
`endif
  );

  inv_sub_bytes_iter #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst), .ip(ipx), .enable(1'b1), .in_valid(ivx), .in_ready(in_ready16),
    .op(op16), .out_valid(ov16), .out_ready(1'b1)
`ifdef INV_SUB_BYTES_CHECK_EN
    , .err(err16)
`endif
  );

`ifndef INV_SUB_BYTES_CHECK_EN
  assign err = 1'b0; assign err1 = 1'b0; assign err16 = 1'b0;
`endif

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Inverse affine map followed by multiplicative inverse (x^254).
  function automatic logic [7:0] inv_sb(input logic [7:0] v);
    logic [7:0] t, r;
    t = {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, t);
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sb(v[8*i +: 8]);
    return r;
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one block, then scramble the inputs to show they are ignored while not IDLE.
  task automatic run_block(input string tag, input logic [127:0] v, input logic en,
                           input int exp_lat, input logic [127:0] exp_op);
    int lat;
    ip = v; enable = en; in_valid = 1'b1;
    step;
    ip = ~v; enable = ~en; in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin step; lat++; end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_op"}, op, exp_op);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    chk({tag, "_rdy_lo"}, 128'(in_ready), 128'(0));
    step;
    out_ready = 1'b0;
    chk({tag, "_rdy_hi"}, 128'(in_ready), 128'(1));
    chk({tag, "_ov_lo"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] r, hold;
    int acc, lat1, lat16;
    logic seen;
    logic [127:0] o1, o16;

    rst = 1'b1; ip = '0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ipx = '0; ivx = 1'b0;
    step; step;
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_op", op, 128'h0);
    chk("rst_err", 128'(err), 128'(0));

    run_block("all63", {16{8'h63}}, 1'b1, 4, 128'h0);
    consume("all63");
    run_block("vec2", 128'h6363636363636363636363ed16007c63, 1'b1, 4,
              128'h000000000000000000000053ff520100);
    consume("vec2");
    run_block("bypass", 128'h0123456789abcdef0011223344556677, 1'b0, 0,
              128'h0123456789abcdef0011223344556677);
    consume("bypass");

    r = {$urandom, $urandom, $urandom, $urandom};
    run_block("rand4", r, 1'b1, 4, model(r));
    hold = model(r);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("stall_ov", 128'(out_valid), 128'(1));
      chk("stall_op", op, hold);
      chk("stall_rdy", 128'(in_ready), 128'(0));
    end
    consume("stall");

    // Reset two cycles into BUSY abandons the block.
    ip = {16{8'h16}}; enable = 1'b1; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rstbusy_rdy", 128'(in_ready), 128'(1));
    chk("rstbusy_ov", 128'(out_valid), 128'(0));
    chk("rstbusy_op", op, 128'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin seen |= out_valid; step; end
    chk("rstbusy_no_ov", 128'(seen), 128'(0));
    run_block("after_rst", {16{8'h16}}, 1'b1, 4, {16{8'hff}});
    consume("after_rst");

    // Back-to-back: one accept every N+2 = 6 cycles.
    ip = {16{8'h7c}}; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      if (in_ready) acc++;
      step;
    end
    in_valid = 1'b0;
    chk("tput_accepts", 128'(acc), 128'(4));
    chk("tput_idle", 128'(in_ready), 128'(1));
    out_ready = 1'b0;

    // LANES=1 and LANES=16 against the software model.
    for (int k = 0; k < 3; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      ipx = r; ivx = 1'b1;
      step;
      ivx = 1'b0;
      lat1 = -1; lat16 = -1; o1 = '0; o16 = '0;
      for (int c = 0; c <= 20; c++) begin
        if (ov1 && lat1 < 0) begin lat1 = c; o1 = op1; end
        if (ov16 && lat16 < 0) begin lat16 = c; o16 = op16; end
        step;
      end
      chk("l1_lat", 128'(lat1), 128'(16));
      chk("l1_op", o1, model(r));
      chk("l16_lat", 128'(lat16), 128'(1));
      chk("l16_op", o16, model(r));
      chk("l1_idle", 128'(in_ready1), 128'(1));
      chk("l16_idle", 128'(in_ready16), 128'(1));
    end
    chk("err_final", 128'({err, err1, err16}), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_sub_bytes_iter.md
# inv_sub_bytes_iter

Iterative inverse-SubBytes unit for the AES decryption datapath. It replaces each of the 16 bytes of a 128-bit state with its inverse S-box value. It time-multiplexes LANES inverse S-boxes over 16/LANES cycles, which trades latency for area. It sits between InvShiftRows and AddRoundKey in the decrypt round and uses a valid/ready handshake on both sides.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ip  in  128  input state; byte i = ip[8i+7:8i].
- enable  in  1  sampled at accept; 0 = bypass (state returned unchanged).
- in_valid  in  1  input block valid.
- in_ready  out  1  unit can accept a block.
- op  out  128  output state; byte ordering same as ip.
- out_valid  out  1  op holds a completed block.
- out_ready  in  1  downstream accepts op.
- err  out  1  sticky self-check failure; present only with INV_SUB_BYTES_CHECK_EN.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: substituting.
  - DONE: out_valid=1.
- N = 16/LANES.
- IDLE, in_valid&&in_ready: data reg <= ip, cnt <= 0, mode <= enable. Next state is BUSY if enable=1, DONE if enable=0.
- BUSY: each cycle replaces bytes cnt*LANES .. cnt*LANES+LANES-1 of data reg with invsbox(byte), then cnt <= cnt+1. When cnt == N-1, next state is DONE. Bytes are processed lowest-index first.
- DONE: op = data reg. On out_valid&&out_ready, next state is IDLE.
- in_ready=0 in BUSY and DONE. ip, enable and in_valid are ignored outside IDLE.
- op is stable while out_valid=1 and out_ready=0.
- cnt width = clog2(N), minimum 1 bit. cnt wraps to 0 on leaving BUSY.
- LANES=16: exactly one BUSY cycle.

## Timing
- Reset, on the edge with rst=1: state IDLE, cnt 0, data reg 0, mode 0, err 0. Afterwards in_ready=1, out_valid=0, op=0.
- Accept at edge E0, enable=1: out_valid high in the cycle after edge E0+N. LANES=4 gives 4 cycles.
- Bypass: out_valid high in the cycle after E0.
- Outputs are registered or state-decoded only; there is no combinational path from ip to op.
- Throughput: one block per N+2 cycles when out_ready is held high.
- in_ready is low for the cycle in which out_valid&&out_ready completes; the next accept occurs at the earliest one cycle later.
- rst during BUSY or DONE: block abandoned, no out_valid, IDLE on the next cycle. rst has priority over every handshake.
- in_valid may be deasserted without acceptance; the unit has no obligation to hold it.

## Configuration
- INV_SUB_BYTES_CHECK_EN defined:
  - Instantiate LANES forward aes_sbox units on the freshly produced bytes.
  - If sbox(invsbox(x)) != x, set err=1 on the same edge as the write.
  - err stays set until rst.
- INV_SUB_BYTES_CHECK_EN undefined: no err port, no forward S-boxes, identical timing otherwise.

## Structure
- Shared AES package holds:
  - the 256-entry inverse S-box constant (alongside the forward table);
  - the state enum (IDLE/BUSY/DONE);
  - the AES_BYTES=16 constant.
- One sub-module: aes_inv_sbox (8-bit in, 8-bit out, combinational lookup into the package table), instantiated LANES times via generate.
- Byte select uses an indexed part-select on cnt*LANES.

## Test plan
- LANES=4, enable=1, ip = 0x63 in every byte -> after 4 cycles op = all 0x00, out_valid=1.
- ip bytes 0..15 = 0x63,0x7c,0x00,0x16,0xed, rest 0x63 -> op bytes 0x00,0x01,0x52,0xff,0x53, rest 0x00; byte order preserved.
- enable=0, ip=0x0123456789abcdef0011223344556677 -> op equals ip one cycle after accept.
- out_ready held 0 for 5 cycles in DONE -> op and out_valid stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
- rst asserted at BUSY cycle 2 -> no out_valid ever for that block; after reset op=0, in_ready=1; a new block completes correctly.
- Sweep LANES in {1,16}, random ip vs. software model, with INV_SUB_BYTES_CHECK_EN -> latency N, err stays 0.
